// File: rtl/seq_divider.sv
`timescale 1ns / 1ps
// seq_divider: sequential 32-bit restoring divider, DIV (signed) and DIVU (unsigned).
// One quotient bit per cycle. done pulses in the cycle after the 34th edge following accept.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   start       request a division (sampled in IDLE only)
//   is_signed   1 = signed (two's complement), 0 = unsigned; sampled with start
//   dividend    numerator; sampled with start
//   divisor     denominator; sampled with start
//   busy        high whenever the FSM is not in IDLE
//   done        one-cycle pulse, results valid
//   quotient    LO result, held until the next operation completes
//   remainder   HI result, held until the next operation completes
//   div_by_zero divisor was zero for the last completed operation
module seq_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {StIdle, StRun, StSign, StDone} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q;
  logic [31:0] rem_q;      // partial remainder
  logic [31:0] quo_q;      // dividend magnitude, shifted out MSB first as quotient bits shift in
  logic [31:0] dvs_q;      // divisor magnitude
  logic        signed_q;
  logic        sign_q_q;
  logic        sign_r_q;
  logic        dz_q;

  logic        shift_b;
  logic [31:0] shift_r;
  logic [32:0] trial;
  logic        accept;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic        dvd_neg;
  logic        dvs_neg;

  assign dvd_neg = is_signed & dividend[31];
  assign dvs_neg = is_signed & divisor[31];

  // One restoring step: shift {rem, quo} left, trial-subtract the divisor as r + ~d + 1.
  // A shifted-out 1 means r >= 2^32 > divisor, so the subtraction always fits.
  assign shift_b = rem_q[31];
  assign shift_r = {rem_q[30:0], quo_q[31]};
  assign trial   = {1'b0, shift_r} + {1'b0, ~dvs_q} + 33'd1;
  assign accept  = shift_b | trial[32];

  // Divide by zero leaves rem = |dividend| and quo = all ones; re-applying the dividend sign
  // restores the original dividend, and the quotient is forced regardless of signs.
  always_comb begin
    q_fix = quo_q;
    r_fix = rem_q;
    if (dz_q) begin
      q_fix = 32'hFFFF_FFFF;
    end else if (signed_q && sign_q_q) begin
      q_fix = ~quo_q + 32'd1;
    end
    if (signed_q && sign_r_q) begin
      r_fix = ~rem_q + 32'd1;
    end
  end

  // Counter runs 0..31 across the iterations, then sits at 32 for one cycle before SIGN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (cnt_q == 6'd32) state_d = StSign;
      StSign:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 6'd0;
      rem_q       <= 32'd0;
      quo_q       <= 32'd0;
      dvs_q       <= 32'd0;
      signed_q    <= 1'b0;
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      dz_q        <= 1'b0;
      quotient    <= 32'd0;
      remainder   <= 32'd0;
      div_by_zero <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (start) begin
            signed_q <= is_signed;
            dz_q     <= (divisor == 32'd0);
            quo_q    <= dvd_neg ? (~dividend + 32'd1) : dividend;
            dvs_q    <= dvs_neg ? (~divisor + 32'd1) : divisor;
            rem_q    <= 32'd0;
            cnt_q    <= 6'd0;
            sign_q_q <= is_signed & (dividend[31] ^ divisor[31]);
            sign_r_q <= dvd_neg;
          end
        end
        StRun: begin
          if (cnt_q != 6'd32) begin
            rem_q <= accept ? trial[31:0] : shift_r;
            quo_q <= {quo_q[30:0], accept};
            cnt_q <= cnt_q + 6'd1;
          end
        end
        StSign: begin
          quotient    <= q_fix;
          remainder   <= r_fix;
          div_by_zero <= dz_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
`timescale 1ns / 1ps
// Scoreboard bench for seq_divider: stimulus pushes expected results, a negedge monitor pops
// and compares whenever done is seen, including the cycle at which done appears.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  seq_divider dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, want no pulse", cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, "_quotient"}, quotient, e.q);
        check({e.name, "_remainder"}, remainder, e.r);
        check({e.name, "_dz"}, {31'd0, div_by_zero}, {31'd0, e.dz});
        check({e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
        check({e.name, "_busy_done"}, {31'd0, busy}, 32'd1);
      end
    end
  end

  // Called at a negedge; start is sampled at the next posedge (E0), done expected after E34.
  task automatic issue(input string name, input bit s, input logic [31:0] a,
                       input logic [31:0] b, input bit chk, input logic [31:0] q,
                       input logic [31:0] r, input bit dz);
    exp_t e;
    start     = 1'b1;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    if (chk) begin
      e.q = q; e.r = r; e.dz = dz; e.cyc = cyc + 35; e.name = name;
      sb.push_back(e);
    end
    @(negedge clk);
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = 1'($urandom_range(0, 1));
    check({name, "_busy_run"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_timeout"}, {31'd0, (n < 100)}, 32'd1);
  endtask

  task automatic run(input string name, input bit s, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] q, input logic [31:0] r, input bit dz);
    issue(name, s, a, b, 1'b1, q, r, dz);
    wait_idle(name);
  endtask

  task automatic check_zero(input string name);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_done"}, {31'd0, done}, 32'd0);
    check({name, "_quotient"}, quotient, 32'd0);
    check({name, "_remainder"}, remainder, 32'd0);
    check({name, "_dz"}, {31'd0, div_by_zero}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100us, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    #1 rst = 1'b1;
    #2 check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    check("after_done_busy", {31'd0, busy}, 32'd0);
    run("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    run("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    run("div_m7_0", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
    run("div_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0);
    run("divu_big_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0);

    // Starts during RUN and DONE are ignored; start in the following IDLE cycle is accepted.
    issue("divu_1000_10", 1'b0, 32'd1000, 32'd10, 1'b1, 32'd100, 32'd0, 1'b0);
    repeat (4) @(negedge clk);
    issue("ign_run", 1'b0, 32'd9, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_done_timeout", {31'd0, (n < 100)}, 32'd1);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd9; divisor = 32'd3;
    @(negedge clk);
    start = 1'b0;
    check("done_start_ignored", {31'd0, busy}, 32'd0);
    run("b2b_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    // Asynchronous reset mid-run aborts without a done pulse.
    issue("abort", 1'b0, 32'hFFFF_FFFF, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (10) @(negedge clk);
    #1 rst = 1'b1;
    #1 check_zero("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    run("divu_ffffffff_3", 1'b0, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 32'd0, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
